// File: rtl/dmem_ctrl.sv
// dmem_ctrl: handshaked, latency-configurable data memory for the load/store
// unit. One request is accepted in IDLE. The access happens after
// WAIT_STATES extra cycles in BUSY, and the response is held in RESP until
// the consumer takes it.
// Memory is word organised with byte lanes. Misaligned, out-of-range and
// illegal-format accesses return err=1 and rdata=0, and never write memory.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_req_valid/o_req_ready request handshake (ready = IDLE)
//   i_req_we/addr/wdata/fmt store flag, byte address, right-aligned data, funct3
//   o_rsp_valid/i_rsp_ready response handshake
//   o_rsp_rdata/o_rsp_err   extended load data (0 for stores/faults), fault flag
//
// state | meaning
// IDLE  | ready for a request; request fields latched on accept
// BUSY  | counting wait states; access performed when the counter is 0
// RESP  | response presented and held until i_rsp_ready
module dmem_ctrl #(
    parameter int SIZE        = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [2:0]  i_req_fmt,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);
    localparam int         AW = $clog2(SIZE);
    localparam int         NW = SIZE / 4;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr, r_wdata;
    logic [2:0]  r_fmt;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [NW];

    logic        w_accept, w_access, w_fault, w_mem_we;
    logic        w_illegal, w_misal, w_oor;
    logic [AW-3:0] w_idx;
    logic [31:0] w_word, w_load, w_wrep;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_lane;

    assign w_accept = (r_state == IDLE) && i_req_valid;
    assign w_access = (r_state == BUSY) && (r_cnt == 4'd0);

    // Stores with the unsigned load formats (100/101) count as illegal.
    assign w_illegal = (r_fmt == 3'b011) || (r_fmt[2:1] == 2'b11) || (r_we && r_fmt[2]);
    assign w_misal   = ((r_fmt[1:0] == 2'b01) && r_addr[0]) ||
                       ((r_fmt == 3'b010) && (r_addr[1:0] != 2'b00));
    // Full-width compare, so any high address bit faults instead of wrapping.
    assign w_oor     = (r_addr >= 32'(SIZE));
    assign w_fault   = w_illegal || w_misal || w_oor;
    assign w_mem_we  = w_access && r_we && !w_fault;

    assign w_idx  = r_addr[AW-1:2];
    assign w_word = r_mem[w_idx];
    assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_byte = w_word[7:0];
        case (r_addr[1:0])
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            2'd3:    w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
    end

    always_comb begin
        w_load = 32'd0;
        case (r_fmt)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = w_word;
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
    end

    always_comb begin
        w_lane = 4'b1111;
        w_wrep = r_wdata;
        case (r_fmt[1:0])
            2'b00: begin
                w_lane = 4'b0001 << r_addr[1:0];
                w_wrep = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_lane = 4'b0011 << r_addr[1:0];
                w_wrep = {2{r_wdata[15:0]}};
            end
            default: begin
                w_lane = 4'b1111;
                w_wrep = r_wdata;
            end
        endcase
    end

    // Storage is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (w_lane[k]) r_mem[w_idx][8*k +: 8] <= w_wrep[8*k +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_req_valid) w_state_nxt = BUSY;
            BUSY:    if (r_cnt == 4'd0) w_state_nxt = RESP;
            RESP:    if (i_rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = (r_state == IDLE);
        o_rsp_valid = (r_state == RESP);
        o_rsp_rdata = r_rdata;
        o_rsp_err   = r_err;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_fmt   <= 3'd0;
        end else if (w_accept) begin
            r_cnt   <= WS;
            r_we    <= i_req_we;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            r_fmt   <= i_req_fmt;
        end else if ((r_state == BUSY) && (r_cnt != 4'd0)) begin
            r_cnt   <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_access) begin
            r_rdata <= (w_fault || r_we) ? 32'd0 : w_load;
            r_err   <= w_fault;
        end else if ((r_state == RESP) && i_rsp_ready) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end
    end
endmodule
